reg_file_dump: RTL and testbench
================================

# reg_file_dump

Sequential read-out engine for the 128 x 128-bit SPU register file. On a start pulse it walks a contiguous, wrapping address range through one register-file read port. It captures each 128-bit register and streams it out over a valid/ready handshake tagged with its address. It is the read-side counterpart of the register-file preload path: verification and debug use it to extract architectural state after a run, and it reuses a read port of the existing register file.

## Interface
Parameters:
- DATA_W, 128, register width; must match the register file.
- ADDR_W, 7, register address width (128 entries).

Ports (MSB-first [0:N-1] vectors, as in the register file):
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  **reset, asynchronous, active-high.**
- start  input  1  one-cycle request; sampled only in IDLE.
- first_addr  input  ADDR_W  first register to dump; sampled with start.
- last_addr  input  ADDR_W  last register to dump, inclusive; sampled with start.
- rd_addr  output  ADDR_W  drives a register-file read address port.
- rd_data  input  DATA_W  combinational read data from that port.
- dump_valid  output  1  dump_data, dump_addr and dump_last are valid.
- dump_ready  input  1  consumer accepts the word when high with dump_valid.
- dump_data  output  DATA_W  captured register contents.
- dump_addr  output  ADDR_W  register index of dump_data.
- dump_last  output  1  current word is the final one of the range.
- busy  output  1  high from the cycle after an accepted start through the DONE state.
- done  output  1  one-cycle pulse after the final handshake.

## Operation
- State machine: IDLE, LOAD, HOLD, DONE.
- IDLE
  - On start: cur <= first_addr, end <= last_addr, go to LOAD.
  - start is ignored in every other state; there is no queuing.
- LOAD
  - rd_addr = cur.
  - Register dump_data <= rd_data, dump_addr <= cur, dump_last <= (cur == end), dump_valid <= 1.
  - Go to HOLD.
- HOLD
  - dump_valid stays high.
  - dump_data, dump_addr and dump_last hold stable until dump_valid && dump_ready.
  - On handshake with dump_last = 0: dump_valid <= 0, cur <= cur + 1 mod 128, go to LOAD.
  - On handshake with dump_last = 1: dump_valid <= 0, go to DONE.
- DONE
  - done = 1 for exactly one cycle, then go to IDLE.
- Range and count
  - Word count = ((last_addr - first_addr) mod 128) + 1.
  - first == last gives one word.
  - last < first wraps through 127 to 0. For example, first=126, last=1 gives 126, 127, 0, 1.
  - first = last + 1 mod 128 dumps all 128 registers.
- Address arithmetic is ADDR_W bits, modulo 2^ADDR_W, with no overflow flag.
- rd_addr outputs cur in all states. In IDLE, cur holds its last value (0 after reset).
- The dump captures whatever rd_data presents in the LOAD cycle. This includes register-file write-bypass data if a write to cur occurs in that same cycle.
- dump_ready is ignored while dump_valid = 0.

## Timing
- Reset values: state IDLE, cur = 0, end = 0, rd_addr = 0, dump_valid = 0, dump_data = 0, dump_addr = 0, dump_last = 0, busy = 0, done = 0.
- Asserting rst in any state returns the block to reset values immediately, without waiting for a clock edge. A partial dump is abandoned and no done pulse is produced.
- Cycle sequence for a start sampled at edge T:
  - Cycle T+1: LOAD, busy = 1.
  - Cycle T+2: dump_valid = 1 for the first word.
- Throughput: with dump_ready held high, one word every 2 cycles.
- Total time for N words with ready held high: done is high in cycle T+2N+1, and busy is 0 from cycle T+2N+2.
- Backpressure: each cycle of dump_ready = 0 in HOLD adds one cycle, with outputs frozen.
- A start in the same cycle as done is ignored. The earliest accepted restart is the first IDLE cycle after DONE.

## Test plan
- Single word: preload r5 = 0x0123..EF. Then start with first=5, last=5 and ready held high. Required: exactly one beat with dump_addr=5, data=0x0123..EF, dump_last=1; done high 3 cycles after start.
- Full sweep: preload rN = {16{N}} bytes for every N. Then start with first=0, last=127 and ready high. Required: 128 beats with dump_addr 0..127 in order, each dump_data matching its preload, dump_last only on address 127, done at cycle T+257.
- Wrap: start with first=126, last=1. Required: beats at addresses 126, 127, 0, 1 in that order, dump_last only on address 1.
- Backpressure: first=10, last=12, with ready low for 3 cycles on every beat. Required: data, address and last stable while stalled; 3 beats total; no word skipped or duplicated.
- Start while busy: pulse start with first=40, last=40 during a dump of 0..3. Required: it is ignored and only 0..3 is emitted. A start issued after done dumps r40.
- Async reset mid-dump: assert rst during HOLD of the second word of 20..30. Required: all outputs go to 0 immediately without a clock edge, and no done pulse. After reset is released, a new start with first=20, last=30 dumps the full range correctly.

Source files
------------

// File: rtl/reg_file_dump.sv
// Sequential read-out engine for the SPU register file: walks a wrapping
// address range through one read port and streams each register out tagged with its index.
module reg_file_dump #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [0:ADDR_W-1] first_addr,
  input  logic [0:ADDR_W-1] last_addr,
  output logic [0:ADDR_W-1] rd_addr,
  input  logic [0:DATA_W-1] rd_data,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [0:DATA_W-1] dump_data,
  output logic [0:ADDR_W-1] dump_addr,
  output logic              dump_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [0:ADDR_W-1] cur;
  logic [0:ADDR_W-1] end_addr;

  // Handshake: a word transfers on a clock edge where dump_valid && dump_ready;
  // once raised, dump_valid and its payload stay frozen until that edge, and
  // dump_ready is don't-care while dump_valid is low.
  logic handshake;
  assign handshake = dump_valid && dump_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_HOLD;
      S_HOLD: if (handshake) state_nxt = dump_last ? S_DONE : S_LOAD;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= '0;
      end_addr   <= '0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_addr  <= '0;
      dump_last  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur      <= first_addr;
            end_addr <= last_addr;
          end
        end
        S_LOAD: begin
          // rd_data may carry write-bypass data for cur; whatever is presented is captured.
          dump_data  <= rd_data;
          dump_addr  <= cur;
          dump_last  <= (cur == end_addr);
          dump_valid <= 1'b1;
        end
        S_HOLD: begin
          if (handshake) begin
            dump_valid <= 1'b0;
            if (!dump_last) cur <= cur + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_addr = cur;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_reg_file_dump.sv
// Bench for reg_file_dump: the bench acts as the register file and checks every
// beat against a queue of expected words computed from the requested range.
module tb_reg_file_dump;

  localparam int DW = 128;
  localparam int AW = 7;
  localparam int EW = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [0:AW-1] first_addr;
  logic [0:AW-1] last_addr;
  logic [0:AW-1] rd_addr;
  logic [0:DW-1] rd_data;
  logic          dump_valid;
  logic          dump_ready;
  logic [0:DW-1] dump_data;
  logic [0:AW-1] dump_addr;
  logic          dump_last;
  logic          busy;
  logic          done;

  logic [DW-1:0] mem [128];
  assign rd_data = mem[rd_addr];

  reg_file_dump #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .first_addr (first_addr),
    .last_addr  (last_addr),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_data  (dump_data),
    .dump_addr  (dump_addr),
    .dump_last  (dump_last),
    .busy       (busy),
    .done       (done)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 128; i++) mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  // mode 0: ready always high, 1: ready low for 3 cycles per beat, 2: random ready.
  // poke_busy pulses a start for r40 mid-dump; poke_done pulses one in the done cycle.
  task automatic run_dump(input int fa, input int la, input int mode,
                          input bit poke_busy, input bit poke_done);
    logic [EW-1:0] exp_q[$];
    logic [AW-1:0] aa;
    int n, k, stalls, wait_cnt, budget;
    bit seen_done, r;
    n = ((la - fa + 128) % 128) + 1;
    for (int i = 0; i < n; i++) begin
      aa = AW'((fa + i) % 128);
      exp_q.push_back({(i == n - 1), aa, mem[aa]});
    end
    @(negedge clk);
    start = 1'b1;
    first_addr = AW'(fa);
    last_addr  = AW'(la);
    dump_ready = 1'b0;
    @(posedge clk);
    k = 0; stalls = 0; wait_cnt = 0; seen_done = 1'b0;
    budget = 10 * n + 20;
    while (!seen_done && k < budget) begin
      @(negedge clk);
      k++;
      start = 1'b0;
      if (k == 1) begin
        check("busy_after_start", busy, 1);
        check("load_no_valid", dump_valid, 0);
      end
      if (k == 2) check("first_valid_t2", dump_valid, 1);
      if (poke_busy && k == 3) begin
        start = 1'b1;
        first_addr = AW'(40);
        last_addr  = AW'(40);
      end
      if (dump_valid) begin
        if (exp_q.size() == 0) check("extra_beat", 1, 0);
        else check("beat", {dump_last, dump_addr, dump_data}, exp_q[0]);
        case (mode)
          0: r = 1'b1;
          1: r = (wait_cnt >= 3);
          default: r = 1'($urandom_range(0, 1));
        endcase
        dump_ready = r;
        if (r) begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          wait_cnt = 0;
        end else begin
          wait_cnt++;
          stalls++;
        end
      end else begin
        dump_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 0);
      end
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", k, 2 * n + 1 + stalls);
        check("queue_drained", exp_q.size(), 0);
      end
    end
    if (!seen_done) check("done_timeout", 0, 1);
    if (poke_done) begin
      start = 1'b1;
      first_addr = AW'(40);
      last_addr  = AW'(40);
    end
    @(negedge clk);
    start = 1'b0;
    dump_ready = 1'b0;
    check("busy_clear", busy, 0);
    check("done_one_cycle", done, 0);
    if (poke_done) begin
      @(negedge clk);
      check("restart_in_done_ignored", busy, 0);
    end
  endtask

  initial begin
    int guard;
    int fa;
    rst = 1'b1;
    start = 1'b0;
    first_addr = '0;
    last_addr = '0;
    dump_ready = 1'b0;
    fill_random();
    #1;
    check("rst_rd_addr", rd_addr, 0);
    check("rst_valid", dump_valid, 0);
    check("rst_data", dump_data, 0);
    check("rst_addr", dump_addr, 0);
    check("rst_last", dump_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // single word
    mem[5] = 128'h0123456789ABCDEF0123456789ABCDEF;
    run_dump(5, 5, 0, 1'b0, 1'b0);

    // full sweep with byte-pattern preload
    for (int i = 0; i < 128; i++) mem[i] = {16{8'(i)}};
    run_dump(0, 127, 0, 1'b0, 1'b0);

    // wrap through 127 -> 0
    run_dump(126, 1, 0, 1'b0, 1'b0);

    // backpressure, 3 stall cycles per beat
    fill_random();
    run_dump(10, 12, 1, 1'b0, 1'b0);

    // start while busy and in the done cycle, then a real restart for r40
    run_dump(0, 3, 0, 1'b1, 1'b1);
    run_dump(40, 40, 0, 1'b0, 1'b0);

    // async reset during HOLD of the second word of 20..30
    @(negedge clk);
    start = 1'b1;
    first_addr = AW'(20);
    last_addr  = AW'(30);
    dump_ready = 1'b0;
    guard = 0;
    while (guard < 20) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (dump_valid && dump_addr == AW'(21)) break;
      dump_ready = dump_valid;
    end
    dump_ready = 1'b0;
    check("reached_second_word", {dump_valid, dump_addr}, {1'b1, AW'(21)});
    #2 rst = 1'b1;
    #1;
    check("arst_valid", dump_valid, 0);
    check("arst_data", dump_data, 0);
    check("arst_addr", dump_addr, 0);
    check("arst_last", dump_last, 0);
    check("arst_rd_addr", rd_addr, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_done_after_abort", {busy, done}, 0);
    end
    run_dump(20, 30, 0, 1'b0, 1'b0);

    // randomized ranges and random ready
    fill_random();
    for (int t = 0; t < 6; t++) begin
      fa = int'($urandom_range(0, 127));
      run_dump(fa, (fa + int'($urandom_range(0, 15))) % 128, 2, 1'b0, 1'b0);
    end
    run_dump(50, 49, 2, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
